// File: rtl/ysyx_22041211_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per
// cycle, sign fix-up in a final cycle, registered result held until consumed.
module ysyx_22041211_divider #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  input  logic [1:0]          div_op_i,
  input  logic [DATA_LEN-1:0] src1,
  input  logic [DATA_LEN-1:0] src2,
  input  logic                flush_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [DATA_LEN-1:0] result_o
);

  // Request side: accepted when div_valid_i & div_ready_o & ~flush_i at a rising edge.
  // Result side: delivered when result_valid_o & result_ready_i & ~flush_i at a rising edge.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_LEN-1:0] rem_q, rem_d;
  logic [DATA_LEN-1:0] quo_q, quo_d;
  logic [DATA_LEN-1:0] dvd_q, dvd_d;
  logic [DATA_LEN-1:0] dvs_q, dvs_d;
  logic [DATA_LEN-1:0] result_q, result_d;
  logic                is_rem_q, is_rem_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;

  logic                is_signed;
  logic                accept;
  logic                div_zero;
  logic                sgn_ovf;
  logic [DATA_LEN:0]   trial;
  logic [DATA_LEN-1:0] abs1, abs2;

  assign div_ready_o    = (state_q == S_IDLE);
  assign result_valid_o = (state_q == S_DONE);
  assign result_o       = result_q;

  assign is_signed = ~div_op_i[0];
  assign accept    = div_valid_i & div_ready_o & ~flush_i;
  assign div_zero  = (src2 == '0);
  assign sgn_ovf   = is_signed & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
  assign abs1      = (is_signed & src1[DATA_LEN-1]) ? (~src1 + 32'd1) : src1;
  assign abs2      = (is_signed & src2[DATA_LEN-1]) ? (~src2 + 32'd1) : src2;
  // 33-bit partial remainder so the shifted-out MSB is not lost in the compare.
  assign trial     = {rem_q, dvd_q[DATA_LEN-1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_rem_d = div_op_i[1];
            qneg_d   = is_signed & (src1[DATA_LEN-1] ^ src2[DATA_LEN-1]);
            rneg_d   = is_signed & src1[DATA_LEN-1];
            if (div_zero) begin
              state_d  = S_DONE;
              result_d = div_op_i[1] ? src1 : '1;
            end else if (sgn_ovf) begin
              state_d  = S_DONE;
              result_d = div_op_i[1] ? '0 : 32'h8000_0000;
            end else begin
              state_d = S_CALC;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = '0;
              dvd_d   = abs1;
              dvs_d   = abs2;
            end
          end
        end
        S_CALC: begin
          dvd_d = {dvd_q[DATA_LEN-2:0], 1'b0};
          if (trial >= {1'b0, dvs_q}) begin
            rem_d = trial[DATA_LEN-1:0] - dvs_q;
            quo_d = {quo_q[DATA_LEN-2:0], 1'b1};
          end else begin
            rem_d = trial[DATA_LEN-1:0];
            quo_d = {quo_q[DATA_LEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_FIX;
        end
        S_FIX: begin
          if (is_rem_q) result_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
          else          result_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
          state_d = S_DONE;
        end
        default: begin
          if (result_ready_i) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_divider.sv
// Bench for the RV32M divider: directed cases, backpressure, flush, reset and
// randomized operations checked against an arithmetic reference model.
module tb_ysyx_22041211_divider;

  logic        clk;
  logic        rst_n;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [1:0]  div_op_i;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  ysyx_22041211_divider #(.DATA_LEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .div_valid_i    (div_valid_i),
    .div_ready_o    (div_ready_o),
    .div_op_i       (div_op_i),
    .src1           (src1),
    .src2           (src2),
    .flush_i        (flush_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // driver: issue one request, wait for its result, stall, then consume it
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall);
    int edges;
    int ready_bad;
    logic [31:0] exp_lat;
    logic [31:0] got;
    exp_q.push_back(ref_model(op, a, b));
    exp_lat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd0 : 32'd33;
    @(negedge clk);
    check({tag, "_ready_idle"}, {31'd0, div_ready_o}, 32'd1);
    div_valid_i = 1'b1;
    div_op_i    = op;
    src1        = a;
    src2        = b;
    @(posedge clk);
    #1;
    div_valid_i = 1'b0;
    div_op_i    = 2'($urandom_range(0, 3));
    src1        = $urandom;
    src2        = $urandom;
    edges       = 0;
    ready_bad   = 0;
    while (!result_valid_o && edges < 100) begin
      if (div_ready_o) ready_bad++;
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), exp_lat);
    check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
    got = result_o;
    for (int i = 0; i < stall; i++) begin
      div_valid_i = 1'b1;
      @(posedge clk);
      #1;
      if (!result_valid_o || result_o !== got || div_ready_o) ready_bad++;
    end
    check({tag, "_hold"}, 32'(ready_bad), 32'd0);
    // scoreboard: compare the delivered result with the oldest expectation
    check({tag, "_result"}, got, exp_q.pop_front());
    // ready and a pending request together: the request must be ignored in DONE
    result_ready_i = 1'b1;
    @(posedge clk);
    #1;
    result_ready_i = 1'b0;
    div_valid_i    = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, result_valid_o}, 32'd0);
    check({tag, "_back_idle"}, {31'd0, div_ready_o}, 32'd1);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_valid_i = 1'b1;
    div_op_i    = op;
    src1        = a;
    src2        = b;
    @(posedge clk);
    #1;
    div_valid_i = 1'b0;
  endtask

  initial begin
    int rise;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n          = 1'b0;
    div_valid_i    = 1'b0;
    div_op_i       = 2'd0;
    src1           = '0;
    src2           = '0;
    flush_i        = 1'b0;
    result_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, result_valid_o}, 32'd0);
    check("rst_ready", {31'd0, div_ready_o}, 32'd1);
    check("rst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("rem_big", 2'b10, 32'h8000_0001, 32'h10, 0);
    run_op("divu_by0", 2'b01, 32'd5, 32'd0, 0);
    run_op("rem_by0", 2'b10, 32'd5, 32'd0, 0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_bp", 2'b01, 32'hFFFF_FFFF, 32'd1, 5);
    run_op("divu_after_bp", 2'b01, 32'd50, 32'd5, 0);

    // flush in IDLE together with a request: not accepted
    @(negedge clk);
    div_valid_i = 1'b1;
    flush_i     = 1'b1;
    @(posedge clk);
    #1;
    div_valid_i = 1'b0;
    flush_i     = 1'b0;
    check("flush_idle_ready", {31'd0, div_ready_o}, 32'd1);

    // flush at the 10th CALC cycle
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_calc_ready", {31'd0, div_ready_o}, 32'd1);
    rise = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid_o) rise++;
    end
    check("flush_calc_no_valid", 32'(rise), 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 0);

    // flush together with result_ready in DONE
    start_op(2'b01, 32'd7, 32'd0);
    check("flush_done_valid", {31'd0, result_valid_o}, 32'd1);
    flush_i        = 1'b1;
    result_ready_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i        = 1'b0;
    result_ready_i = 1'b0;
    check("flush_done_drop", {31'd0, result_valid_o}, 32'd0);
    check("flush_done_ready", {31'd0, div_ready_o}, 32'd1);

    // asynchronous reset mid-CALC
    start_op(2'b00, 32'h1234_5678, 32'd77);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, div_ready_o}, 32'd1);
    check("arst_valid", {31'd0, result_valid_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rise = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (result_valid_o) rise++;
    end
    check("arst_no_valid", 32'(rise), 32'd0);
    run_op("after_rst", 2'b10, 32'hFFFF_FF00, 32'd7, 0);

    // randomized operations, with occasional zero/overflow/small operands
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op("rand", rop, ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_divider.md
Name: ysyx_22041211_divider

Overview:
- Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU) for the EXU.
- It is the responder side of a request/response handshake. The EXU issues an operation with operands; the unit returns one registered result.
- It runs in parallel with the single-cycle ALU. It is iterative, producing one quotient bit per cycle (restoring algorithm).

Parameters:
- DATA_LEN, 32, operand/result width (only 32 supported).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- div_valid_i  input  1  request valid.
- div_ready_o  output  1  unit can accept a request (high only in IDLE).
- div_op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- src1  input  DATA_LEN  dividend.
- src2  input  DATA_LEN  divisor.
- flush_i  input  1  synchronous kill of any in-flight or pending operation.
- result_valid_o  output  1  result available.
- result_ready_i  input  1  consumer accepts result.
- result_o  output  DATA_LEN  quotient or remainder per latched op.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; result_o=0; result_valid_o=0; div_ready_o=1.
  - Internal counter, remainder, quotient and operand registers are cleared.
  - Reset mid-operation discards the operation entirely.
- div_ready_o = (state==IDLE) and is combinational from state.
- Acceptance occurs on an edge where div_valid_i & div_ready_o & ~flush_i. At acceptance, op, sign flags and |operands| are latched. Inputs need not stay stable afterwards.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> DONE on acceptance if src2==0 or the op is signed with src1==0x80000000 and src2==0xFFFFFFFF (special case). The result is loaded at that same edge, so result_valid_o is high in the cycle after acceptance.
  - IDLE -> CALC on any other acceptance: counter=0, rem=0, dvd=|src1|, dvs=|src2| (absolute value only for DIV/REM).
  - CALC, each cycle: t={rem[31:0],dvd[31]} as 33 bits; dvd<<=1; if t>={1'b0,dvs} then rem=t-dvs and quotient LSB=1, else rem=t[31:0] and quotient LSB=0. The quotient shifts into the low end. counter++.
  - CALC -> FIX on the edge completing iteration 32 (counter==31).
  - FIX: sign correction; result_o is registered. DIV: quotient is negated if sign(src1)!=sign(src2). REM: remainder takes the sign of src1. Unsigned ops pass through. FIX -> DONE.
  - DONE: result_valid_o=1 and result_o is held stable. On result_valid_o & result_ready_i: -> IDLE, result_valid_o=0 next cycle. result_o keeps its last value.
- Latency, normal path: with acceptance at edge k, result_valid_o is high after edge k+33 (32 CALC edges + FIX). Throughput is one operation per ≥34 cycles plus the handshake.
- Special-case results:
  - Divide by zero: DIV/DIVU=0xFFFFFFFF; REM/REMU=src1 (unmodified).
  - Signed overflow: DIV=0x80000000; REM=0.
- flush_i:
  - Has highest priority after reset. In any state: next state=IDLE, result_valid_o=0 next cycle, and the in-flight result is discarded.
  - flush_i with div_valid_i in IDLE: the request is not accepted.
  - flush_i with result_ready_i in DONE: treated as a flush, returns to IDLE; the consumer must not count the result as delivered.
- No new request is accepted in DONE, even in the same cycle as the result handshake. The earliest next acceptance is the edge after the return to IDLE.
- Arithmetic is modulo 2^32. The comparison uses a 33-bit subtract to avoid losing the carry.

Test Plan:
- DIVU 100/7, then REMU 100/7 -> results 14 and 2. result_valid_o rises exactly 33 edges after the accept edge; div_ready_o stays low from acceptance until the return to IDLE.
- Signed ops:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
  - REM 0x80000001/0x10 -> 0xFFFFFFF1.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; result_valid_o one cycle after acceptance.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: complete DIVU 0xFFFFFFFF/1 and hold result_ready_i=0 for 5 cycles. result_o=0xFFFFFFFF and result_valid_o=1 are held, and a new div_valid_i is ignored. Raising result_ready_i returns the unit to IDLE, and the next request is accepted one cycle later.
- Flush and reset:
  - Assert flush_i at the 10th CALC cycle -> result_valid_o never rises; div_ready_o=1 the next cycle; a following DIVU 9/3 returns 3.
  - Pull rst_n low asynchronously mid-CALC -> all outputs go to reset values immediately; after release, normal operation resumes.
